// File: rtl/cnn_pkg.sv
// cnn_pkg: shared widths, FSM state type and helpers for the CNN pixel front end.
package cnn_pkg;

    localparam int PIXEL_W = 8;

    // Unsigned-to-INT8 offset; subtracting it is the same as inverting the MSB.
    localparam logic [PIXEL_W-1:0] INT8_OFFSET = 8'd128;

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    // A frame is streamable when both dimensions fit the array and the image fits the RAM.
    function automatic logic cfg_valid(
        input logic [7:0] w,
        input logic [7:0] h,
        input int         max_dim,
        input int         addr_w
    );
        int area;
        area = int'(w) * int'(h);
        return (w != 8'd0) && (int'(w) <= max_dim) &&
               (h != 8'd0) && (int'(h) <= max_dim) &&
               (area <= (1 << addr_w));
    endfunction

    // Map a stored byte onto the accelerator's signed pixel encoding.
    function automatic logic [PIXEL_W-1:0] to_int8(
        input logic [PIXEL_W-1:0] raw,
        input logic               convert
    );
        return convert ? (raw ^ INT8_OFFSET) : raw;
    endfunction

endpackage

// File: rtl/frame_ram_1w1r.sv
// frame_ram_1w1r: simple dual-port frame store, one write port, one registered read port, no reset.
module frame_ram_1w1r
    import cnn_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int DATA_W = PIXEL_W
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [0:(1 << ADDR_W)-1];

    // Host write port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read port: data appears one cycle after the address and holds when not reading.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/pixel_stream_source.sv
// pixel_stream_source: replays a host-loaded frame as a row-major INT8 pixel strobe stream.
// Build option: define PIXEL_STREAM_INT8_CONV_EN to convert unsigned 0-255 pixels to INT8
// (value - 128); otherwise the stored byte is passed through unchanged.
module pixel_stream_source
    import cnn_pkg::*;
#(
    parameter int MAX_DIM = 8,
    parameter int ADDR_W  = 6,
    parameter int DATA_W  = PIXEL_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [7:0]        img_width,
    input  logic [7:0]        img_height,
    input  logic              start,
    input  logic              stall,
    output logic [DATA_W-1:0] pixel_out,
    output logic              valid_out,
    output logic [7:0]        row_out,
    output logic [7:0]        col_out,
    output logic              last_out,
    output logic              busy,
    output logic              cfg_err
);

`ifdef PIXEL_STREAM_INT8_CONV_EN
    localparam logic CONVERT = 1'b1;
`else
    localparam logic CONVERT = 1'b0;
`endif

    state_t            state_q, state_d;
    logic [7:0]        width_q, width_d;
    logic [7:0]        height_q, height_d;
    logic [7:0]        row_q, row_d;
    logic [7:0]        col_q, col_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic              issue;
    logic              last_issue;
    logic              reject;
    logic              pixel_seen_q;
    logic              ram_wr_en;
    logic [DATA_W-1:0] ram_rd_data;

    // Writes are only accepted while idle so a frame cannot change under the reader.
    // Addresses beyond the RAM cannot be expressed on an ADDR_W-bit port, so no extra check.
    assign ram_wr_en = wr_en && (state_q == IDLE);
    assign busy      = (state_q == STREAM);

    // Row-major order makes row*W+col a plain running count, so the read pointer just increments.
    frame_ram_1w1r #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_frame_ram (
        .clk     (clk),
        .wr_en   (ram_wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (issue),
        .rd_addr (rd_ptr_q),
        .rd_data (ram_rd_data)
    );

    // Next-state logic: frame acceptance, issue cycles and raster counter advance.
    always_comb begin
        state_d    = state_q;
        width_d    = width_q;
        height_d   = height_q;
        row_d      = row_q;
        col_d      = col_q;
        rd_ptr_d   = rd_ptr_q;
        issue      = 1'b0;
        last_issue = 1'b0;
        reject     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (cfg_valid(img_width, img_height, MAX_DIM, ADDR_W)) begin
                        width_d  = img_width;
                        height_d = img_height;
                        row_d    = 8'd0;
                        col_d    = 8'd0;
                        rd_ptr_d = '0;
                        state_d  = STREAM;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            STREAM: begin
                if (!stall) begin
                    issue    = 1'b1;
                    rd_ptr_d = rd_ptr_q + ADDR_W'(1);
                    if (col_q == width_q - 8'd1) begin
                        col_d = 8'd0;
                        row_d = row_q + 8'd1;
                        if (row_q == height_q - 8'd1) begin
                            last_issue = 1'b1;
                            state_d    = IDLE;
                        end
                    end else begin
                        col_d = col_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state, latched frame geometry and raster counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            width_q  <= 8'd0;
            height_q <= 8'd0;
            row_q    <= 8'd0;
            col_q    <= 8'd0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            width_q  <= width_d;
            height_q <= height_d;
            row_q    <= row_d;
            col_q    <= col_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Output strobes line up with the RAM read latency; coordinates hold through stall gaps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_out    <= 1'b0;
            last_out     <= 1'b0;
            cfg_err      <= 1'b0;
            row_out      <= 8'd0;
            col_out      <= 8'd0;
            pixel_seen_q <= 1'b0;
        end else begin
            valid_out <= issue;
            last_out  <= last_issue;
            cfg_err   <= reject;
            if (issue) begin
                row_out      <= row_q;
                col_out      <= col_q;
                pixel_seen_q <= 1'b1;
            end
        end
    end

    // The RAM has no reset, so the pixel is masked to zero until the first read after reset.
    assign pixel_out = pixel_seen_q ? to_int8(ram_rd_data, CONVERT) : '0;

endmodule

// File: doc/pixel_stream_source.md
Name: pixel_stream_source

Overview:
- Frame-buffered pixel transmitter: the driving end of the CNN pixel-input interface (`valid_in` / `pixel_in` of the accelerator top).
- A host loads one unsigned 0-255 image into internal RAM, then pulses `start`.
- The block replays the image in row-major order as a signed INT8 strobe stream, with per-pixel coordinates and an end-of-frame marker.
- It replaces file-driven stimulus, so the pipeline can run self-contained on silicon or FPGA.

Parameters:
- MAX_DIM, 8: maximum image width and height.
- ADDR_W, 6: RAM address width; must satisfy 2**ADDR_W >= MAX_DIM*MAX_DIM.
- DATA_W, 8: pixel width; fixed at 8 for the INT8 pipeline.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- wr_en  in  1  host write strobe into frame RAM.
- wr_addr  in  ADDR_W  write address, row*img_width+col.
- wr_data  in  8  unsigned pixel, 0-255.
- img_width  in  8  frame width; sampled on start.
- img_height  in  8  frame height; sampled on start.
- start  in  1  one-cycle request to stream a frame.
- stall  in  1  gap request; no pixel is issued in a cycle where stall=1.
- pixel_out  out  8  signed pixel to the accelerator's pixel_in.
- valid_out  out  1  pixel strobe to the accelerator's valid_in.
- row_out  out  8  row index of pixel_out.
- col_out  out  8  column index of pixel_out.
- last_out  out  1  high with the final pixel of the frame.
- busy  out  1  high from the start acceptance through the last pixel.
- cfg_err  out  1  one-cycle pulse when start is rejected.

Behaviour:
- Reset (async, rst=1): FSM goes to IDLE. pixel_out, valid_out, row_out, col_out, last_out, busy and cfg_err are all 0. RAM contents are not cleared.
- FSM states: IDLE, STREAM.
- IDLE, start=1 with valid config: latch width W and height H, clear row/col counters, go to STREAM. busy=1 from the next cycle.
- Valid config means 1<=W<=MAX_DIM, 1<=H<=MAX_DIM, and W*H<=2**ADDR_W.
- IDLE, start=1 with invalid config: pulse cfg_err for one cycle and stay in IDLE.
- STREAM issue: each cycle with stall=0 is an issue cycle.
  - Read address row*W+col into a synchronous RAM read.
  - Advance col; on col==W-1, wrap col to 0 and increment row.
- Output timing: valid_out, pixel_out, row_out and col_out are registered. Outputs in cycle t+1 reflect the issue in cycle t.
  - First valid_out comes 2 cycles after start is sampled: one cycle to enter STREAM, one cycle of read latency.
  - With stall=0 throughout, the stream has no gaps: W*H consecutive valid cycles.
- stall=1 in STREAM: counters hold and valid_out=0 in the next cycle. pixel_out, row_out and col_out hold their last values.
- Last pixel: the issue at row=H-1, col=W-1 sets last_out=1 together with its valid_out. The FSM returns to IDLE on that issue, and busy drops in the same cycle last_out is high.
- start while busy is ignored, with no error.
- wr_en while busy is ignored, so the frame stays consistent. Writes to an address >= 2**ADDR_W are dropped.
- A write and a read to the same address in the same cycle (only possible in IDLE-to-STREAM overlap) is disallowed; writes are gated by busy.
- Back-to-back frames: start may be asserted in the cycle last_out is high, while the FSM is already in IDLE. The new frame's first valid then arrives 2 cycles later.
- Reset mid-frame: all outputs drop asynchronously and no further valid_out is produced. A fresh start is required afterwards.

Optional Feature:
- Macro: PIXEL_STREAM_INT8_CONV_EN.
- Defined: pixel_out = wr_data - 128, implemented as an MSB inversion. For example 0 -> -128, 128 -> 0, 255 -> 127.
- Undefined: pixel_out passes the stored byte through unchanged. The host then preloads INT8 values.

Decomposition:
- Shared package cnn_pkg holds:
  - PIXEL_W = 8
  - the state enum typedef {IDLE, STREAM}
  - the INT8 offset constant 128
  - a function cfg_valid(W, H, MAX_DIM, ADDR_W)
- One sub-module: frame_ram_1w1r. It is a simple dual-port RAM, 2**ADDR_W x 8, with a synchronous registered read and no reset.

Test Plan:
- Basic frame, conversion macro on: load RAM[k]=k for an 8x8 image, start, stall=0.
  - Expect 64 contiguous valid_out beats, the first exactly 2 cycles after start.
  - Beat k has pixel_out=k-128 and row/col equal to k/8 and k%8.
  - last_out on beat 63 only (pixel_out=-65); busy falls in that same cycle.
- Stall gaps: same 8x8 frame, stall=1 on every 3rd cycle.
  - Expect exactly 64 valid beats, in order with no duplicates or skips.
  - valid_out=0 one cycle after each stall cycle.
- Config error: start with W=0 (H=8), then with W=9 (H=8).
  - Expect a cfg_err one-cycle pulse each time.
  - busy and valid_out stay 0.
- Non-square frame: W=5, H=3 with RAM[k]=200.
  - Expect 15 beats with pixel_out=72.
  - col wraps 4->0 at beats 5 and 10.
  - last_out at row=2, col=4.
- Reset and restart: assert rst at the 20th beat of an 8x8 frame.
  - All outputs go to 0 immediately, with no further valid_out.
  - A new start yields the full 64 beats from (0,0).
  - start and wr_en pulses during the restarted frame have no effect.
- Macro off: RAM[k]=8'h80.
  - pixel_out=-128 raw, with no conversion.
  - Beat count and timing identical to the first scenario.
